// File: rtl/branch_predict_unit.sv
// Branch predictor: a table of 2-bit saturating counters indexed by PC bits, with
// statistics counters for resolved and mispredicted conditional branches.
// Optional feature: define BPU_GLOBAL_HISTORY_EN to XOR a global taken/not-taken
// history into both the fetch and update indices (gshare-style).
module branch_predict_unit #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned PC_W    = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [PC_W-1:0]    if_pc,
  input  logic [6:0]         if_opcode,
  output logic               pred_taken,
`ifdef BPU_GLOBAL_HISTORY_EN
  output logic [INDEX_W-1:0] pred_hist,
  input  logic [INDEX_W-1:0] upd_hist,
`endif
  input  logic               upd_valid,
  input  logic               upd_is_jump,
  input  logic [PC_W-1:0]    upd_pc,
  input  logic               upd_taken,
  input  logic               upd_pred,
  output logic               flush,
  output logic [CNT_W-1:0]   branch_cnt,
  output logic [CNT_W-1:0]   mispred_cnt
);

  localparam int unsigned Entries  = 2 ** INDEX_W;
  localparam logic [6:0]  OpBranch = 7'b1100011;

  logic [1:0]         table_q [Entries];
  logic [1:0]         table_d [Entries];
  logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;
  logic [INDEX_W-1:0] if_idx, upd_idx;
  logic               cond_upd, mispred;

  // Only the word-index bits of the PCs select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[PC_W-1:INDEX_W+2], if_pc[1:0],
                            upd_pc[PC_W-1:INDEX_W+2], upd_pc[1:0]};

`ifdef BPU_GLOBAL_HISTORY_EN
  logic [INDEX_W-1:0] hist_q, hist_d;

  assign pred_hist = hist_q;
  // Update uses the history that travelled with the instruction, not the live one.
  assign if_idx    = if_pc[INDEX_W+1:2] ^ hist_q;
  assign upd_idx   = upd_pc[INDEX_W+1:2] ^ upd_hist;

  // Shift the resolved outcome into the history on each conditional update.
  always_comb begin
    hist_d = hist_q;
    if (cond_upd) begin
      hist_d = INDEX_W'({hist_q, upd_taken});
    end
  end

  // History register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  assign if_idx  = if_pc[INDEX_W+1:2];
  assign upd_idx = upd_pc[INDEX_W+1:2];
`endif

  assign cond_upd = upd_valid & ~upd_is_jump;
  assign mispred  = upd_taken ^ upd_pred;

  // Prediction reads the registered table directly: no same-cycle bypass.
  assign pred_taken  = (if_opcode == OpBranch) & table_q[if_idx][1];
  assign flush       = upd_valid & (upd_is_jump | mispred);
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  // Next-state for the counter table and the saturating statistics counters.
  always_comb begin
    table_d       = table_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (cond_upd) begin
      if (upd_taken) begin
        if (table_q[upd_idx] != 2'b11) table_d[upd_idx] = table_q[upd_idx] + 2'b01;
      end else begin
        if (table_q[upd_idx] != 2'b00) table_d[upd_idx] = table_q[upd_idx] - 2'b01;
      end
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + 1'b1;
      if (mispred && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  // State registers; reset leaves every entry weakly not-taken.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < Entries; i++) table_q[i] <= 2'b01;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      table_q       <= table_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus random
// traffic compared against an array-based reference model. Two instances share
// inputs: one with default CNT_W, one with CNT_W=4 to exercise saturation.
module tb_branch_predict_unit;

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [63:0] if_pc, upd_pc;
  logic [6:0]  if_opcode;
  logic        upd_valid, upd_is_jump, upd_taken, upd_pred;
  logic        pred_taken, flush, pred_taken_s, flush_s;
  logic [15:0] branch_cnt, mispred_cnt;
  logic [3:0]  branch_cnt_s, mispred_cnt_s;
`ifdef BPU_GLOBAL_HISTORY_EN
  logic [3:0]  pred_hist, pred_hist_s, upd_hist;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: counter values 0..3, unbounded event counts, history.
  int m_tab[16];
  int m_br, m_mis, m_hist;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .if_pc      (if_pc),
    .if_opcode  (if_opcode),
    .pred_taken (pred_taken),
`ifdef BPU_GLOBAL_HISTORY_EN
    .pred_hist  (pred_hist),
    .upd_hist   (upd_hist),
`endif
    .upd_valid  (upd_valid),
    .upd_is_jump(upd_is_jump),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_pred   (upd_pred),
    .flush      (flush),
    .branch_cnt (branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  branch_predict_unit #(.CNT_W(4)) dut_sat (
    .clk        (clk),
    .arst_n     (arst_n),
    .if_pc      (if_pc),
    .if_opcode  (if_opcode),
    .pred_taken (pred_taken_s),
`ifdef BPU_GLOBAL_HISTORY_EN
    .pred_hist  (pred_hist_s),
    .upd_hist   (upd_hist),
`endif
    .upd_valid  (upd_valid),
    .upd_is_jump(upd_is_jump),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_pred   (upd_pred),
    .flush      (flush_s),
    .branch_cnt (branch_cnt_s),
    .mispred_cnt(mispred_cnt_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  function automatic int word_idx(input logic [63:0] pc);
    return int'((pc >> 2) & 64'hF);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_tab[i] = 1;
    m_br   = 0;
    m_mis  = 0;
    m_hist = 0;
  endtask

  // Apply one clock edge's worth of architectural effect.
  task automatic model_update();
    int uh, idx;
    uh = 0;
`ifdef BPU_GLOBAL_HISTORY_EN
    uh = int'(upd_hist);
`endif
    if (upd_valid && !upd_is_jump) begin
      idx = word_idx(upd_pc) ^ uh;
      if (upd_taken) m_tab[idx] = (m_tab[idx] == 3) ? 3 : m_tab[idx] + 1;
      else           m_tab[idx] = (m_tab[idx] == 0) ? 0 : m_tab[idx] - 1;
      m_br++;
      if (upd_taken != upd_pred) m_mis++;
`ifdef BPU_GLOBAL_HISTORY_EN
      m_hist = ((m_hist << 1) | int'(upd_taken)) & 15;
`endif
    end
  endtask

  task automatic check_comb();
    logic exp_pred, exp_flush;
    exp_pred  = (if_opcode == OpBranch) && (m_tab[word_idx(if_pc) ^ m_hist] >= 2);
    exp_flush = upd_valid && (upd_is_jump || (upd_taken != upd_pred));
    check("pred_taken", pred_taken, exp_pred);
    check("pred_taken_sat", pred_taken_s, exp_pred);
    check("flush", flush, exp_flush);
`ifdef BPU_GLOBAL_HISTORY_EN
    check("pred_hist", pred_hist, m_hist);
`endif
  endtask

  task automatic check_counts();
    check("branch_cnt", branch_cnt, sat(m_br, 65535));
    check("mispred_cnt", mispred_cnt, sat(m_mis, 65535));
    check("branch_cnt_sat", branch_cnt_s, sat(m_br, 15));
    check("mispred_cnt_sat", mispred_cnt_s, sat(m_mis, 15));
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic do_cycle();
    #1 check_comb();
    @(posedge clk);
    if (arst_n) model_update();
    @(negedge clk);
    check_counts();
  endtask

  task automatic set_upd(input logic v, input logic j, input logic [63:0] pc,
                         input logic t, input logic p);
    upd_valid   = v;
    upd_is_jump = j;
    upd_pc      = pc;
    upd_taken   = t;
    upd_pred    = p;
  endtask

  initial begin
    arst_n    = 1'b0;
    if_pc     = 64'h40;
    if_opcode = OpBranch;
`ifdef BPU_GLOBAL_HISTORY_EN
    upd_hist  = '0;
`endif
    set_upd(1'b1, 1'b1, 64'h40, 1'b0, 1'b0);
    model_reset();

    // Reset state, and combinational outputs live during reset.
    #1;
    check_counts();
    check_comb();
    @(negedge clk);
    set_upd(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;

    // Cold branch at 0x40 mispredicted taken twice, then predicted taken.
    if_pc = 64'h40;
    set_upd(1'b1, 1'b0, 64'h40, 1'b1, 1'b0);
    #1 check("req33_cold_pred", pred_taken, 1'b0);
    do_cycle();
    do_cycle();
    set_upd(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    #1 check_comb();
`ifndef BPU_GLOBAL_HISTORY_EN
    check("req33_pred", pred_taken, 1'b1);
    check("req33_mispred", mispred_cnt, 16'd2);
    check("req33_branch", branch_cnt, 16'd2);
`endif
    @(negedge clk);

    // Saturate 0x10 at strong-taken, one not-taken keeps it predicting taken.
    if_pc = 64'h10;
    for (int i = 0; i < 5; i++) begin
      set_upd(1'b1, 1'b0, 64'h10, 1'b1, 1'b1);
      do_cycle();
    end
    set_upd(1'b1, 1'b0, 64'h10, 1'b0, 1'b1);
    do_cycle();
    set_upd(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    #1 check_comb();
`ifndef BPU_GLOBAL_HISTORY_EN
    check("req34_pred", pred_taken, 1'b1);
`endif
    @(negedge clk);

    // Jump resolution: flush, no table or statistics change.
    set_upd(1'b1, 1'b1, 64'h10, 1'b1, 1'b0);
    #1 check("req35_flush", flush, 1'b1);
    do_cycle();

    // Same-index read and write: old value this cycle, new value next cycle.
    if_pc = 64'h8;
    set_upd(1'b1, 1'b0, 64'h8, 1'b1, 1'b0);
    #1;
`ifndef BPU_GLOBAL_HISTORY_EN
    check("req36_same_cycle", pred_taken, 1'b0);
`endif
    do_cycle();
    set_upd(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    #1 check_comb();
`ifndef BPU_GLOBAL_HISTORY_EN
    check("req36_next_cycle", pred_taken, 1'b1);
`endif
    @(negedge clk);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int sel;
      if_pc = {$urandom, $urandom};
      sel   = int'($urandom_range(0, 3));
      if_opcode = (sel < 2) ? OpBranch : (sel == 2) ? OpJal : 7'($urandom);
      set_upd($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, {$urandom, $urandom},
              1'($urandom), 1'($urandom));
`ifdef BPU_GLOBAL_HISTORY_EN
      upd_hist = 4'($urandom);
`endif
      do_cycle();
    end

    // Statistics saturation in the narrow instance.
    if_opcode = OpBranch;
    for (int i = 0; i < 20; i++) begin
      set_upd(1'b1, 1'b0, {$urandom, $urandom}, 1'b1, 1'b0);
      do_cycle();
    end
    check("req37_mispred_sat", mispred_cnt_s, 4'hF);
    check("req37_branch_sat", branch_cnt_s, 4'hF);

    // Reset pulse while an update is pending: that update is dropped.
    set_upd(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    #2 arst_n = 1'b0;
    model_reset();
    #1 check_counts();
    @(posedge clk);
    #1 check_counts();
    @(negedge clk);
    arst_n = 1'b1;
    set_upd(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if_pc = 64'(i) << 2;
      #1 check("post_rst_pred", pred_taken, 1'b0);
      check("post_rst_pred_sat", pred_taken_s, 1'b0);
    end
    @(negedge clk);
    check_counts();

`ifdef BPU_GLOBAL_HISTORY_EN
    // History shifts in outcomes LSB-first: taken then not-taken gives 2'b10.
    set_upd(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    upd_hist = 4'h0;
    do_cycle();
    set_upd(1'b1, 1'b0, 64'h4, 1'b0, 1'b0);
    upd_hist = 4'h1;
    do_cycle();
    set_upd(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    #1 check("req38_hist", pred_hist[1:0], 2'b10);
    if_pc = 64'h0;
    #1 check_comb();
    if_pc = 64'h4;
    #1 check_comb();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, meaning log2 of pattern-table entries (2^INDEX_W 2-bit counters).
REQ-002 SHALL have parameter PC_W, default 64, meaning program-counter width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 arst_n  input  1  reset, asynchronous, active-low.
REQ-006 if_pc  input  PC_W  fetch-stage PC.
REQ-007 if_opcode  input  7  fetch-stage instruction opcode[6:0].
REQ-008 pred_taken  output  1  prediction for fetched instruction; travels down the pipe with it.
REQ-009 upd_valid  input  1  a branch or jump resolves this cycle in decode.
REQ-010 upd_is_jump  input  1  resolving instruction is JAL (opcode 1101111).
REQ-011 upd_pc  input  PC_W  PC of resolving instruction.
REQ-012 upd_taken  input  1  actual outcome (register-equal result for branches).
REQ-013 upd_pred  input  1  pred_taken that travelled with the resolving instruction.
REQ-014 flush  output  1  squash younger fetched instruction.
REQ-015 branch_cnt  output  CNT_W  resolved conditional branches since reset.
REQ-016 mispred_cnt  output  CNT_W  mispredicted conditional branches since reset.

Function
REQ-017 Fetch index SHALL be if_pc[INDEX_W+1:2]; update index SHALL be upd_pc[INDEX_W+1:2].
REQ-018 pred_taken SHALL be combinational: 1 only when if_opcode==1100011 and selected counter bit[1]==1; 0 for every other opcode, including JAL.
REQ-019 Counters SHALL be 2-bit saturating: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-020 On a clock edge with upd_valid=1 and upd_is_jump=0, the addressed counter SHALL increment if upd_taken=1 (saturate at 11), else decrement (saturate at 00).
REQ-021 upd_valid=1 with upd_is_jump=1 SHALL NOT modify any counter or statistics counter.
REQ-022 flush SHALL be combinational: upd_valid & (upd_is_jump | (upd_taken != upd_pred)).
REQ-023 Same-index read and write in one cycle: pred_taken SHALL reflect the pre-update counter value (no bypass); the new value is visible from the next cycle.
REQ-024 branch_cnt SHALL increment by 1 on each conditional update (REQ-020); mispred_cnt SHALL increment when additionally upd_taken != upd_pred.
REQ-025 Both statistics counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 Prediction latency SHALL be 0 cycles; update latency 1 cycle.
REQ-027 upd_valid=0 SHALL leave all state unchanged and force flush=0.

Reset
REQ-028 arst_n low SHALL asynchronously set every table counter to 01, branch_cnt and mispred_cnt to 0, and global history (if present) to 0.
REQ-029 Reset asserted mid-update SHALL discard that update; first post-reset prediction for any branch SHALL be 0.
REQ-030 Combinational outputs pred_taken and flush SHALL follow their inputs during reset, using the reset table state.

Configuration
REQ-031 Macro BPU_GLOBAL_HISTORY_EN defined: an INDEX_W-bit global history register SHALL shift in upd_taken (LSB) on each conditional update; port pred_hist (output, INDEX_W, history used for this prediction) and port upd_hist (input, INDEX_W, pred_hist that travelled with the resolving instruction) SHALL exist; fetch index = if_pc[INDEX_W+1:2] XOR history; update index = upd_pc[INDEX_W+1:2] XOR upd_hist.
REQ-032 Macro undefined: no history register, no pred_hist/upd_hist ports, indexing per REQ-017.

Verification
REQ-033 Post-reset, if_opcode=1100011, if_pc=0x40 -> pred_taken=0; upd of 0x40 taken, taken, upd_pred=0 -> flush=1 both cycles, then pred_taken=1, mispred_cnt=2, branch_cnt=2.
REQ-034 Five taken updates of PC 0x10 then one not-taken -> counter 11 then 10, pred_taken stays 1.
REQ-035 upd_valid=1, upd_is_jump=1, upd_pred=0 -> flush=1, branch_cnt unchanged, table unchanged.
REQ-036 if_pc=upd_pc=0x8, counter 01, upd_taken=1 same cycle -> pred_taken=0 that cycle, 1 next cycle.
REQ-037 CNT_W=4, 20 mispredicted updates -> mispred_cnt holds 0xF; arst_n pulse mid-cycle -> counts 0, all entries predict 0.
REQ-038 With BPU_GLOBAL_HISTORY_EN, updates taken, not-taken -> pred_hist=2'b10 in LSBs; PCs 0x0 and 0x4 map per XOR index.
